usb_fs_in_arb_rr: RTL and testbench
===================================

// Module: usb_fs_in_arb_rr
// PURPOSE
// Registered round-robin arbiter for IN endpoints; successor to the fixed-priority IN arbiter.
// Grants one of NUM_IN_EPS requesters and muxes its data bytes toward the IN protocol engine.
// Holds the grant while the protocol engine is mid-transaction.
// Optional hold limit preempts a hogging endpoint between transactions.
// PARAMETERS
// NUM_IN_EPS  5'd4  number of IN endpoint requesters, 1..16
// DATA_W      8     width of each endpoint data lane
// MAX_HOLD    1024  grant-hold limit in clk cycles; 0 disables preemption
// PORTS
// clk             in   1                 system clock
// reset           in   1                 synchronous, active-high
// in_ep_req       in   NUM_IN_EPS        per-endpoint request, level
// in_ep_grant     out  NUM_IN_EPS        one-hot grant, registered
// in_ep_data      in   NUM_IN_EPS*DATA_W packed endpoint data; lane i = [i*DATA_W +: DATA_W]
// arb_in_ep_data  out  DATA_W            data lane of the granted endpoint; 0 when no grant
// pe_busy         in   1                 protocol engine mid-transaction; freezes the grant
// grant_valid     out  1                 |in_ep_grant
// grant_idx       out  IDX_W             index of the granted endpoint; IDX_W = (N>1) ? $clog2(N) : 1
// arb_preempt     out  1                 1-cycle pulse when a grant is revoked by the hold limit
// BEHAVIOUR
// - Reset:
//   - in_ep_grant=0, grant_valid=0, grant_idx=0, arb_preempt=0.
//   - rr_ptr=0, hold_cnt=0, state=IDLE.
//   - Reset mid-grant drops the grant on the next edge, regardless of pe_busy.
// - FSM IDLE:
//   - If any in_ep_req is set, select the first requester scanning rr_ptr, rr_ptr+1, ... (mod N).
//   - Register its one-hot grant; go to GRANT. Request-to-grant latency is 1 cycle.
// - FSM GRANT, normal release:
//   - On !in_ep_req[g] && !pe_busy: clear the grant next edge, set rr_ptr <= (g+1) mod N, go to IDLE.
//   - The earliest regrant is the edge after that, so there is at least 1 dead cycle between grants.
// - FSM GRANT, request dropped while pe_busy:
//   - Keep the grant and the data mux stable until pe_busy falls, then release as above.
// - Hold counter:
//   - hold_cnt is cleared on entry to GRANT and increments each GRANT cycle.
//   - It saturates at MAX_HOLD.
// - Preemption:
//   - Triggers when MAX_HOLD != 0, hold_cnt == MAX_HOLD, !pe_busy, and another endpoint is requesting.
//   - Action: revoke the grant, pulse arb_preempt for 1 cycle, set rr_ptr <= (g+1) mod N, go to IDLE.
//   - No preemption if g is the sole requester; the grant persists.
// - pe_busy in IDLE is ignored. The arbiter grants, and the protocol engine owns sequencing.
// - arb_in_ep_data: combinational AND-OR mux of the lanes, driven by the registered one-hot grant.
//   No extra latency beyond the grant register.
// - grant_idx tracks the registered grant; it is 0 when no grant is active.
// - in_ep_grant is never more than one-hot. Requests from ungranted endpoints never affect the mux.
// - NUM_IN_EPS=1: rr_ptr is constant 0 and preemption can never fire (no other requester).
// - Requests may toggle freely. Only a level present in the IDLE cycle is considered.
// TESTING
// - reset, then req=4'b0100 -> grant=4'b0100 one cycle later, grant_idx=2, arb_in_ep_data=lane2.
// - req=4'b1111 held, each EP drops req after 3 cycles in turn -> grants cycle 0,1,2,3,0 with 1 dead cycle each.
// - grant on EP1, req[1] drops while pe_busy=1 for 5 cycles -> grant held 5 cycles, released the edge after pe_busy=0.
// - MAX_HOLD=8, EP0 holds req, EP3 requests, pe_busy=0 -> arb_preempt pulse at hold_cnt=8, next grant=EP3.
// - MAX_HOLD=8, EP0 sole requester for 50 cycles -> no preempt, grant stays 4'b0001.
// - reset asserted mid-grant with pe_busy=1 -> in_ep_grant=0 and arb_in_ep_data=0 next cycle, rr_ptr=0.

Source files
------------

// File: rtl/usb_fs_in_arb_rr_if.sv
// IN endpoint arbiter bus: endpoint requests/data in,
// registered grant and muxed data lane out.
interface usb_fs_in_arb_rr_if #(
  parameter int NUM_IN_EPS = 4,
  parameter int DATA_W     = 8
);
  localparam int IDX_W =
    (NUM_IN_EPS > 1) ? $clog2(NUM_IN_EPS) : 1;

  logic [NUM_IN_EPS-1:0]        in_ep_req;
  logic [NUM_IN_EPS-1:0]        in_ep_grant;
  logic [NUM_IN_EPS*DATA_W-1:0] in_ep_data;
  logic [DATA_W-1:0]            arb_in_ep_data;
  logic                         pe_busy;
  logic                         grant_valid;
  logic [IDX_W-1:0]             grant_idx;
  logic                         arb_preempt;

  modport master (
    input  in_ep_req,
    input  in_ep_data,
    input  pe_busy,
    output in_ep_grant,
    output arb_in_ep_data,
    output grant_valid,
    output grant_idx,
    output arb_preempt
  );

  modport slave (
    output in_ep_req,
    output in_ep_data,
    output pe_busy,
    input  in_ep_grant,
    input  arb_in_ep_data,
    input  grant_valid,
    input  grant_idx,
    input  arb_preempt
  );
endinterface

// File: rtl/usb_fs_in_arb_rr.sv
// Registered round-robin IN endpoint arbiter with
// transaction-safe grant hold and optional hog preemption.
module usb_fs_in_arb_rr #(
  parameter int NUM_IN_EPS = 4,
  parameter int DATA_W     = 8,
  parameter int MAX_HOLD   = 1024
) (
  input logic clk,
  input logic reset,
  usb_fs_in_arb_rr_if.master bus
);
  localparam int N = NUM_IN_EPS;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int HW =
    (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic             pre_q, pre_d;

  logic             pick_ok;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] nxt_ptr;
  logic             own_req;
  logic             others;
  logic             hold_max;
  logic             preempt_ok;
  logic [DATA_W-1:0] mux;

  // Walk backwards so the first hit in scan order wins.
  always_comb begin
    int k;
    pick_ok  = 1'b0;
    pick_idx = '0;
    k        = 0;
    for (int j = N - 1; j >= 0; j--) begin
      k = int'(ptr_q) + j;
      if (k >= N) k = k - N;
      if (bus.in_ep_req[k]) begin
        pick_ok  = 1'b1;
        pick_idx = IDX_W'(k);
      end
    end
  end

  assign nxt_ptr = (idx_q == IDX_W'(N - 1))
                 ? '0 : idx_q + 1'b1;
  assign own_req  = bus.in_ep_req[idx_q];
  assign others   = |(bus.in_ep_req & ~grant_q);
  assign hold_max = (hold_q == HW'(MAX_HOLD));
  assign preempt_ok = (MAX_HOLD != 0) && hold_max
                   && !bus.pe_busy && others;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    pre_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_ok) begin
          state_d          = GRANT;
          grant_d          = '0;
          grant_d[pick_idx] = 1'b1;
          idx_d            = pick_idx;
          hold_d           = '0;
        end
      end
      GRANT: begin
        if (!own_req && !bus.pe_busy) begin
          state_d = IDLE;
          grant_d = '0;
          idx_d   = '0;
          ptr_d   = nxt_ptr;
          hold_d  = '0;
        end else if (preempt_ok) begin
          state_d = IDLE;
          grant_d = '0;
          idx_d   = '0;
          ptr_d   = nxt_ptr;
          hold_d  = '0;
          pre_d   = 1'b1;
        end else if (!hold_max) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      pre_q   <= pre_d;
    end
  end

  // AND-OR mux keyed by the registered one-hot grant.
  always_comb begin
    mux = '0;
    for (int i = 0; i < N; i++) begin
      mux = mux
          | (bus.in_ep_data[i*DATA_W +: DATA_W]
             & {DATA_W{grant_q[i]}});
    end
  end

  assign bus.in_ep_grant    = grant_q;
  assign bus.grant_valid    = |grant_q;
  assign bus.grant_idx      = idx_q;
  assign bus.arb_preempt    = pre_q;
  assign bus.arb_in_ep_data = mux;
endmodule

// File: tb/tb_usb_fs_in_arb_rr.sv
// Scoreboard bench for usb_fs_in_arb_rr: per-cycle model
// predictions queued by the driver, checked by a monitor.
module tb_usb_fs_in_arb_rr;
  localparam int N  = 4;
  localparam int MH = 8;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] idx;
    logic       v;
    logic       p;
    logic [7:0] d;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        cur_rst  = 1'b1;
  logic [3:0]  cur_req  = '0;
  logic        cur_busy = 1'b0;
  logic [31:0] cur_data = '0;

  usb_fs_in_arb_rr_if #(
    .NUM_IN_EPS(N),
    .DATA_W(8)
  ) bus ();

  assign bus.in_ep_req  = cur_req;
  assign bus.pe_busy    = cur_busy;
  assign bus.in_ep_data = cur_data;

  usb_fs_in_arb_rr #(
    .NUM_IN_EPS(N),
    .DATA_W(8),
    .MAX_HOLD(MH)
  ) dut (
    .clk(clk),
    .reset(cur_rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;
  exp_t sbq[$];

  int m_owner = -1;
  int m_ptr   = 0;
  int m_held  = 0;
  bit m_pre   = 1'b0;

  // Model: owner index, next scan start and cycles held.
  function automatic void model_update();
    bit oth;
    m_pre = 1'b0;
    if (cur_rst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_held  = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int e;
        e = (m_ptr + k) % N;
        if (cur_req[e]) begin
          m_owner = e;
          m_held  = 0;
          break;
        end
      end
    end else begin
      oth = 1'b0;
      for (int k = 0; k < N; k++)
        if (k != m_owner && cur_req[k]) oth = 1'b1;
      if (!cur_req[m_owner] && !cur_busy) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end else if (m_held == MH && !cur_busy && oth) begin
        m_pre   = 1'b1;
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end else if (m_held < MH) begin
        m_held = m_held + 1;
      end
    end
  endfunction

  task automatic step(input logic [3:0] req,
                      input logic busy,
                      input logic rst);
    exp_t e;
    @(posedge clk);
    model_update();
    #1;
    cur_req  = req;
    cur_busy = busy;
    cur_rst  = rst;
    cur_data = $urandom;
    e.g   = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0;
    e.idx = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
    e.v   = (m_owner >= 0);
    e.p   = m_pre;
    e.d   = (m_owner >= 0)
          ? cur_data[m_owner*8 +: 8] : 8'h00;
    sbq.push_back(e);
  endtask

  exp_t mon_e, mon_a;
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      mon_a = {bus.in_ep_grant, bus.grant_idx,
               bus.grant_valid, bus.arb_preempt,
               bus.arb_in_ep_data};
      checks++;
      if (mon_a !== mon_e) begin
        failures++;
        $display("FAIL sb t=%0t got g=%b i=%0d v=%b p=%b d=%h want g=%b i=%0d v=%b p=%b d=%h",
                 $time, mon_a.g, mon_a.idx, mon_a.v,
                 mon_a.p, mon_a.d, mon_e.g, mon_e.idx,
                 mon_e.v, mon_e.p, mon_e.d);
      end
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(4'b0, 1'b0, 1'b1);
    step(4'b0, 1'b0, 1'b1);
  endtask

  initial begin
    bit ok;
    bit seen;
    int n;
    int pc;
    logic [3:0] g_at;
    logic [3:0] r;
    logic b;
    logic rs;

    // reset and single request
    do_reset();
    sample();
    chk("rst_grant", bus.in_ep_grant, 0);
    chk("rst_valid", bus.grant_valid, 0);
    chk("rst_idx", bus.grant_idx, 0);
    chk("rst_pre", bus.arb_preempt, 0);
    chk("rst_data", bus.arb_in_ep_data, 0);
    step(4'b0100, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    sample();
    chk("t1_grant", bus.in_ep_grant, 4'b0100);
    chk("t1_idx", bus.grant_idx, 2);
    chk("t1_data", bus.arb_in_ep_data, cur_data[23:16]);
    step(4'b0000, 1'b0, 1'b0);

    // round-robin rotation with all requesting
    do_reset();
    for (int k = 0; k < 5; k++) begin
      ok = 1'b0;
      for (int t = 0; t < 6; t++) begin
        step(4'b1111, 1'b0, 1'b0);
        sample();
        if (bus.grant_valid) begin
          ok = 1'b1;
          break;
        end
      end
      chk("rr_wait", ok, 1);
      chk("rr_idx", bus.grant_idx, k % N);
      step(4'b1111, 1'b0, 1'b0);
      step(4'b1111, 1'b0, 1'b0);
      step(4'b1111 & ~(4'b0001 << (k % N)),
           1'b0, 1'b0);
    end

    // request dropped while protocol engine busy
    do_reset();
    step(4'b0010, 1'b0, 1'b0);
    ok = 1'b1;
    for (int t = 0; t < 5; t++) begin
      step(4'b0000, 1'b1, 1'b0);
      sample();
      if (bus.in_ep_grant !== 4'b0010) ok = 1'b0;
    end
    chk("busy_hold", ok, 1);
    step(4'b0000, 1'b0, 1'b0);
    sample();
    chk("busy_last", bus.in_ep_grant, 4'b0010);
    step(4'b0000, 1'b0, 1'b0);
    sample();
    chk("busy_rel", bus.in_ep_grant, 0);

    // hold-limit preemption by EP3
    do_reset();
    step(4'b0001, 1'b0, 1'b0);
    seen = 1'b0;
    n    = 0;
    g_at = '0;
    for (int t = 1; t <= 20; t++) begin
      step(4'b1001, 1'b0, 1'b0);
      sample();
      if (bus.arb_preempt) begin
        seen = 1'b1;
        n    = t;
        g_at = bus.in_ep_grant;
        break;
      end
    end
    chk("pre_seen", seen, 1);
    chk("pre_lat", n, 10);
    chk("pre_g0", g_at, 0);
    step(4'b1001, 1'b0, 1'b0);
    sample();
    chk("pre_next", bus.in_ep_grant, 4'b1000);
    chk("pre_pulse", bus.arb_preempt, 0);

    // sole requester never preempted
    do_reset();
    step(4'b0001, 1'b0, 1'b0);
    pc = 0;
    for (int t = 0; t < 50; t++) begin
      step(4'b0001, 1'b0, 1'b0);
      sample();
      if (bus.arb_preempt) pc++;
    end
    chk("sole_pre", pc, 0);
    chk("sole_grant", bus.in_ep_grant, 4'b0001);

    // reset mid-grant with busy high
    do_reset();
    step(4'b0100, 1'b0, 1'b0);
    step(4'b0100, 1'b1, 1'b0);
    step(4'b0100, 1'b1, 1'b0);
    sample();
    chk("mid_grant", bus.in_ep_grant, 4'b0100);
    step(4'b0100, 1'b1, 1'b1);
    step(4'b1111, 1'b1, 1'b0);
    sample();
    chk("mid_g0", bus.in_ep_grant, 0);
    chk("mid_d0", bus.arb_in_ep_data, 0);
    step(4'b1111, 1'b0, 1'b0);
    sample();
    chk("mid_ptr", bus.grant_idx, 0);
    chk("mid_v", bus.grant_valid, 1);

    // randomized traffic
    r = '0;
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(0, 3) == 0)
        r = 4'($urandom_range(0, 15));
      b  = ($urandom_range(0, 9) < 3);
      rs = ($urandom_range(0, 199) == 0);
      step(r, b, rs);
    end
    step(4'b0, 1'b0, 1'b0);
    sample();
    chk("sb_drain", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
